icache_fill: RTL
================

Name: icache_fill

Overview:
Direct-mapped instruction cache with line-fill controller. Sits directly upstream of the core's fetch/decode path. Serves 32-bit instruction words by word address (PC). On a miss, fetches the whole line from backing instruction memory over a req/ack handshake. The core sees data_ready low until the word is served from a valid line.

Parameters:
ADDR_WIDTH, 16, word-address width (matches PC width)
DATA_WIDTH, 32, instruction word width
INDEX_BITS, 4, log2 of line count (16 lines)
OFFSET_BITS, 2, log2 of words per line (4 words)

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  reset, synchronous, active-high
clk_en  input  1  lookup enable; low freezes the lookup/output path only
flush  input  1  invalidate all lines
read_valid  input  1  core requests a fetch at read_addr this cycle
read_addr  input  ADDR_WIDTH  word address of requested instruction
read_data  output  DATA_WIDTH  instruction word, registered
data_ready  output  1  read_data is valid for the address requested in the previous enabled cycle
mem_req  output  1  fill request to backing memory
mem_addr  output  ADDR_WIDTH  word address of the fill beat
mem_ack  input  1  memory accepted mem_addr; mem_rdata valid this cycle
mem_rdata  input  DATA_WIDTH  fill data

Behaviour:
- Address split: tag = read_addr[ADDR_WIDTH-1 : INDEX_BITS+OFFSET_BITS] (10 bits at defaults), index = next INDEX_BITS, offset = low OFFSET_BITS.
- Storage: data array of 2^(INDEX_BITS+OFFSET_BITS) words, plus a tag and a valid bit per line.
- Reset (rst=1 at posedge): all valid bits 0, state IDLE, mem_req 0, mem_addr 0, read_data 0, data_ready 0, fill counter 0.
- States: IDLE, FILL.
- IDLE, clk_en=1, read_valid=1, hit (valid and tag match):
  - read_data <= word; data_ready <= 1. Latency 1 cycle.
- IDLE, clk_en=1, read_valid=1, miss:
  - data_ready <= 0.
  - Latch line base address {tag, index, 0}.
  - Fill counter <= 0, mem_req <= 1, mem_addr <= line base.
  - Go to FILL.
- IDLE, clk_en=1, read_valid=0: data_ready <= 0.
- clk_en=0: read_data and data_ready hold; the lookup does not happen. The FILL handshake continues regardless of clk_en, so no beat is lost.
- FILL:
  - data_ready = 0.
  - mem_req and mem_addr are held stable until mem_ack=1 is sampled.
  - On each mem_ack: write mem_rdata to data[index][counter], counter++, mem_addr++.
  - On the ack of the last beat (counter = 2^OFFSET_BITS - 1): write tag, set valid, mem_req <= 0, return to IDLE.
  - Beats are strictly sequential from offset 0; there is no critical-word-first.
- Core contract: read_addr/read_valid are ignored during FILL. The core holds read_addr while data_ready=0. The first IDLE cycle re-looks up and hits, so the total miss penalty is fill beats + 2 cycles minimum.
- mem_ack while mem_req=0: ignored.
- flush:
  - Clears all valid bits in one cycle; data_ready <= 0 that cycle.
  - If asserted in FILL, the fill runs to completion (the handshake is not abandoned), but the filled line is left invalid.
  - Flush coincident with the last-beat ack: the line ends invalid (flush wins).
- Reset mid-FILL: mem_req drops on the next posedge and all state returns to reset values. The memory must tolerate an abandoned request.
- Replacement: direct-mapped; a miss overwrites the indexed line unconditionally.
- Address wrap: a fill never crosses a line, so mem_addr stays within the line base .. base+3.

Test Plan:
1. Cold miss:
   - Stimulus: after reset, read_valid=1, read_addr=0x0000; memory acks each beat immediately with data 0xA0+n.
   - Required response: mem_addr sequence 0x0000, 0x0001, 0x0002, 0x0003; then data_ready=1 with read_data=0x000000A0, and no further mem_req.
2. Hit after fill:
   - Stimulus: read_addr=0x0002 on the next cycle.
   - Required response: data_ready=1 one cycle later, read_data=0x000000A2, mem_req stays 0.
3. Conflict eviction:
   - Stimulus: read 0x0040 (same index, tag 1), then 0x0000.
   - Required response: both miss and refill; mem_addr 0x0040..0x0043, then 0x0000..0x0003.
4. Stalled memory:
   - Stimulus: hold mem_ack low 3 cycles on every beat.
   - Required response: mem_req=1 and mem_addr are constant across the stall; the fill completes correctly after 16 cycles of beats.
5. Flush during fill:
   - Stimulus: assert flush during the second beat of a fill for 0x0010.
   - Required response: all 4 beats are still requested; the following lookup of 0x0010 misses again.
6. clk_en low:
   - Stimulus: after a hit, drop clk_en for 2 cycles while changing read_addr.
   - Required response: read_data and data_ready hold their values.

Source files
------------

// File: rtl/icache_fill.sv
// Direct-mapped instruction cache with a sequential line-fill controller.
// Serves one word per cycle on a hit and refills a whole line over a req/ack handshake on a miss.
module icache_fill #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_BITS  = 4,
  parameter int OFFSET_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  flush,
  input  logic                  read_valid,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  data_ready,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << (INDEX_BITS + OFFSET_BITS);

  typedef enum logic {
    S_IDLE,
    S_FILL
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [DATA_WIDTH-1:0]  r_data [WORDS];
  logic [TAG_BITS-1:0]    r_tag  [LINES];
  logic [LINES-1:0]       r_valid;
  logic                   r_fill_flushed;
  logic [OFFSET_BITS-1:0] r_cnt;
  logic [DATA_WIDTH-1:0]  r_read_data;
  logic                   r_data_ready;
  logic                   r_mem_req;
  logic [ADDR_WIDTH-1:0]  r_mem_addr;

  logic [TAG_BITS-1:0]    w_tag;
  logic [INDEX_BITS-1:0]  w_index;
  logic [OFFSET_BITS-1:0] w_offset;
  logic [TAG_BITS-1:0]    w_fill_tag;
  logic [INDEX_BITS-1:0]  w_fill_index;
  logic                   w_hit;
  logic                   w_lookup;
  logic                   w_miss_start;
  logic                   w_beat;
  logic                   w_last;

  assign w_tag        = read_addr[ADDR_WIDTH-1 -: TAG_BITS];
  assign w_index      = read_addr[OFFSET_BITS +: INDEX_BITS];
  assign w_offset     = read_addr[OFFSET_BITS-1:0];
  assign w_fill_tag   = r_mem_addr[ADDR_WIDTH-1 -: TAG_BITS];
  assign w_fill_index = r_mem_addr[OFFSET_BITS +: INDEX_BITS];
  assign w_hit        = r_valid[w_index] && (r_tag[w_index] == w_tag);
  // A flush cycle suppresses the lookup so a miss never starts alongside an invalidate.
  assign w_lookup     = (r_state == S_IDLE) && clk_en && !flush && read_valid;
  assign w_miss_start = w_lookup && !w_hit;
  assign w_beat       = (r_state == S_FILL) && r_mem_req && mem_ack;
  assign w_last       = w_beat && (r_cnt == '1);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_miss_start) w_next_state = S_FILL;
      S_FILL: if (w_last)       w_next_state = S_IDLE;
      default:                  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // The indexed line is invalidated at miss start so stale words are never served mid-fill.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_valid <= '0;
    end else begin
      if (w_miss_start) r_valid[w_index] <= 1'b0;
      if (w_last && !r_fill_flushed) r_valid[w_fill_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                              r_fill_flushed <= 1'b0;
    else if (w_miss_start)                r_fill_flushed <= 1'b0;
    else if (flush && r_state == S_FILL)  r_fill_flushed <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_beat) r_data[{w_fill_index, r_cnt}] <= mem_rdata;
    if (w_last) r_tag[w_fill_index] <= w_fill_tag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_read_data  <= '0;
      r_data_ready <= 1'b0;
    end else if (flush) begin
      r_data_ready <= 1'b0;
    end else if (r_state == S_FILL) begin
      r_data_ready <= 1'b0;
    end else if (clk_en) begin
      if (read_valid && w_hit) begin
        r_read_data  <= r_data[{w_index, w_offset}];
        r_data_ready <= 1'b1;
      end else begin
        r_data_ready <= 1'b0;
      end
    end
  end

  // Only the offset field advances, so mem_addr never leaves the line being filled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_cnt      <= '0;
    end else if (w_miss_start) begin
      r_mem_req  <= 1'b1;
      r_mem_addr <= {read_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
      r_cnt      <= '0;
    end else if (w_beat) begin
      r_cnt                        <= r_cnt + 1'b1;
      r_mem_addr[OFFSET_BITS-1:0]  <= r_cnt + 1'b1;
      if (w_last) r_mem_req <= 1'b0;
    end
  end

  assign read_data  = r_read_data;
  assign data_ready = r_data_ready;
  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;

endmodule
